// File: rtl/gpio_in_fifo_pkg.sv
// Shared definitions for the buffered GPIO input block: read FSM encoding and status layout.
// Status register packs per-channel nonempty flags in the low byte and sticky overflow flags in the high byte.
package gpio_in_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int STAT_NE_LSB  = 0;
  localparam int STAT_OVF_LSB = 8;

endpackage

// File: rtl/gpio_in_fifo_chan.sv
// One input channel FIFO; push lands next edge, head is combinational and bypasses din when empty.
// No backpressure: a push into a full FIFO with no same-cycle pop is dropped and flagged by ovf_pulse.
module gpio_in_fifo_chan #(
  parameter int width = 16,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [width-1:0] din,
  output logic [width-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             ovf_pulse
);

  localparam int PW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(depth));
  // An empty FIFO presents the incoming word so a waiting read can take it in the push cycle.
  assign head  = empty ? din : mem_q[rptr_q];

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    ovf_pulse = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      rd_en     = pop && (!empty || push);
      wr_en     = push && (!full || rd_en);
      ovf_pulse = push && !wr_en;
      if (wr_en) begin
        mem_d[wptr_q] = din;
        wptr_d        = wptr_q + PW'(1);
      end
      if (rd_en) rptr_d = rptr_q + PW'(1);
      if (wr_en && !rd_en) count_d = count_q + (PW+1)'(1);
      else if (!wr_en && rd_en) count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gpio_in_fifo.sv
// Multi-channel FIFO-buffered GPIO input on the CPU bus; reads complete 1 cycle after acceptance or after data arrives.
// Reads of an empty channel stall in WAIT indefinitely; writes flush a channel and always acknowledge next cycle.
module gpio_in_fifo
  import gpio_in_fifo_pkg::*;
#(
  parameter int size_addr = 3,
  parameter int size      = 4,
  parameter int width     = 16,
  parameter int depth     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [size_addr-1:0]    address,
  input  logic [15:0]             data_in,
  output logic [15:0]             data_out,
  output logic                    ready_r,
  output logic                    ready_w,
  input  logic [size-1:0]         port_write,
  input  logic [size*width-1:0]   port_in,
  output logic [size-1:0]         port_full
);

  state_t                 state_q, state_d;
  logic [size_addr-1:0]   addr_q, addr_d, sel_addr;
  logic [15:0]            data_out_q, data_out_d, status_w;
  logic                   ready_w_q, ready_w_d;
  logic [size-1:0]        ovf_q, ovf_d;
  logic [size-1:0]        empty, ovf_pulse, flush, pop, avail, sel_hot;
  logic [width-1:0]       head [size];
  logic [width-1:0]       sel_head;
  logic                   sel_avail, is_chan, is_status, clr_ovf;
  logic                   unused_data_in;

  assign unused_data_in = ^data_in;

  for (genvar g = 0; g < size; g++) begin : g_chan
    assign flush[g] = write && (address == size_addr'(g));
    // A flush discards any same-cycle push, so it also hides that push from a waiting read.
    assign avail[g] = !flush[g] && (!empty[g] || port_write[g]);

    gpio_in_fifo_chan #(.width(width), .depth(depth)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .push      (port_write[g]),
      .pop       (pop[g]),
      .flush     (flush[g]),
      .din       (port_in[g*width +: width]),
      .head      (head[g]),
      .empty     (empty[g]),
      .full      (port_full[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  always_comb begin
    sel_addr = (state_q == ST_IDLE) ? address : addr_q;
    sel_hot  = '0;
    sel_head = '0;
    status_w = '0;
    for (int i = 0; i < size; i++) begin
      sel_hot[i] = (sel_addr == size_addr'(i));
      if (sel_hot[i]) sel_head = head[i];
      status_w[STAT_NE_LSB + i]  = !empty[i];
      status_w[STAT_OVF_LSB + i] = ovf_q[i];
    end
    is_chan   = |sel_hot;
    sel_avail = |(sel_hot & avail);
    is_status = (sel_addr == size_addr'(size));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_out_q <= '0;
      ready_w_q  <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      ready_w_q  <= ready_w_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    pop        = '0;
    clr_ovf    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read && !write) begin
          addr_d  = address;
          state_d = ST_ACK;
          if (is_chan) begin
            if (sel_avail) begin
              pop        = sel_hot;
              data_out_d = 16'(sel_head);
            end else begin
              state_d = ST_WAIT;
            end
          end else if (is_status) begin
            data_out_d = status_w;
            clr_ovf    = 1'b1;
          end else begin
            data_out_d = '0;
          end
        end
      end
      ST_WAIT: begin
        if (sel_avail) begin
          state_d    = ST_ACK;
          pop        = sel_hot;
          data_out_d = 16'(sel_head);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A new overflow on the clearing edge survives so it is not lost.
  always_comb begin
    ready_w_d = write;
    ovf_d     = ((clr_ovf ? '0 : ovf_q) & ~flush) | ovf_pulse;
  end

  always_comb begin
    ready_r  = (state_q == ST_ACK);
    ready_w  = ready_w_q;
    data_out = data_out_q;
  end

endmodule

// File: tb/tb_gpio_in_fifo.sv
// Self-checking bench for gpio_in_fifo against a queue-based reference model.
module tb_gpio_in_fifo;

  localparam int SA = 3;
  localparam int SZ = 4;
  localparam int W  = 16;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            reset, read, write;
  logic [SA-1:0]   address;
  logic [15:0]     data_in, data_out;
  logic            ready_r, ready_w;
  logic [SZ-1:0]   port_write, port_full;
  logic [SZ*W-1:0] port_in;

  int checks = 0;
  int errors = 0;

  typedef logic [15:0] q_t[$];
  q_t           mq [SZ];
  logic [SZ-1:0] movf;

  gpio_in_fifo #(.size_addr(SA), .size(SZ), .width(W), .depth(D)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .data_in(data_in), .data_out(data_out), .ready_r(ready_r), .ready_w(ready_w),
    .port_write(port_write), .port_in(port_in), .port_full(port_full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < SZ; i++) mq[i].delete();
    movf = '0;
  endfunction

  function automatic void model_push(input int ch, input logic [15:0] v);
    if (mq[ch].size() < D) mq[ch].push_back(v);
    else movf[ch] = 1'b1;
  endfunction

  function automatic logic [15:0] model_status();
    logic [15:0] s = '0;
    for (int i = 0; i < SZ; i++) begin
      s[i]     = (mq[i].size() != 0);
      s[8 + i] = movf[i];
    end
    return s;
  endfunction

  function automatic logic [15:0] model_read(input int a);
    logic [15:0] r = '0;
    if (a < SZ) begin
      if (mq[a].size() != 0) r = mq[a].pop_front();
    end else if (a == SZ) begin
      r    = model_status();
      movf = '0;
    end
    return r;
  endfunction

  function automatic logic [SZ-1:0] model_full();
    logic [SZ-1:0] f = '0;
    for (int i = 0; i < SZ; i++) f[i] = (mq[i].size() == D);
    return f;
  endfunction

  // ---------------- drivers ----------------
  task automatic push1(input int ch, input logic [15:0] v);
    port_write = '0;
    port_in    = '0;
    port_write[ch] = 1'b1;
    port_in[ch*W +: W] = v;
    tick();
    port_write = '0;
    model_push(ch, v);
  endtask

  task automatic bus_read(input int a, output logic [15:0] d, output int lat);
    read    = 1'b1;
    address = SA'(a);
    tick();
    read = 1'b0;
    lat  = 1;
    while (ready_r !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    d = data_out;
    tick();
  endtask

  task automatic bus_write(input int a, output logic ack);
    write   = 1'b1;
    address = SA'(a);
    tick();
    write = 1'b0;
    ack   = ready_w;
    if (a < SZ) begin
      mq[a].delete();
      movf[a] = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] d, exp;
    int lat;
    reset = 1'b1; read = 0; write = 0; address = '0; data_in = '0;
    port_write = '0; port_in = '0;
    #3 reset = 1'b0;
    model_clear();
    tick(); tick();
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
    checks++; if (ready_r !== 1'b0) begin errors++; $display("FAIL reset_ready_r: got %b expected 0", ready_r); end
    checks++; if (ready_w !== 1'b0) begin errors++; $display("FAIL reset_ready_w: got %b expected 0", ready_w); end
    checks++; if (port_full !== '0) begin errors++; $display("FAIL reset_port_full: got %b expected 0", port_full); end
    reset = 1'b1;
    tick();
    exp = model_read(SZ);
    bus_read(SZ, d, lat);
    checks++; if (d !== exp || lat != 1) begin errors++; $display("FAIL reset_status: got %h lat %0d expected %h lat 1", d, lat, exp); end
  endtask

  task automatic test_basic_read();
    logic [15:0] d, exp;
    int lat;
    push1(2, 16'h1234);
    exp = model_read(2);
    bus_read(2, d, lat);
    checks++; if (d !== exp || lat != 1) begin errors++; $display("FAIL basic_read: got %h lat %0d expected %h lat 1", d, lat, exp); end
    exp = model_read(SZ);
    bus_read(SZ, d, lat);
    checks++; if (d !== exp || d[2] !== 1'b0) begin errors++; $display("FAIL basic_status: got %h expected %h", d, exp); end
  endtask

  task automatic test_blocking_read();
    int early = 0;
    read = 1'b1; address = SA'(1);
    tick();
    read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ready_r === 1'b1) early++;
      tick();
    end
    checks++; if (early != 0) begin errors++; $display("FAIL blocking_wait: got %0d early ready_r expected 0", early); end
    port_write = 4'b0010; port_in = '0; port_in[1*W +: W] = 16'h00AB;
    tick();
    port_write = '0;
    checks++; if (ready_r !== 1'b1 || data_out !== 16'h00AB) begin errors++; $display("FAIL blocking_data: got ready_r %b data %h expected 1 00ab", ready_r, data_out); end
    tick();
    checks++; if (ready_r !== 1'b0) begin errors++; $display("FAIL blocking_pulse: got %b expected 0", ready_r); end
  endtask

  task automatic test_overflow();
    logic [15:0] d, exp;
    int lat;
    logic [15:0] vals [5] = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55};
    for (int i = 0; i < 5; i++) begin
      push1(0, vals[i]);
      if (i == 3) begin
        checks++; if (port_full[0] !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", port_full[0]); end
      end
    end
    exp = model_read(SZ);
    bus_read(SZ, d, lat);
    checks++; if (d !== exp || d !== 16'h0101) begin errors++; $display("FAIL ovf_status1: got %h expected %h", d, exp); end
    exp = model_read(SZ);
    bus_read(SZ, d, lat);
    checks++; if (d !== exp || d !== 16'h0001) begin errors++; $display("FAIL ovf_status2: got %h expected %h", d, exp); end
    for (int i = 0; i < 4; i++) begin
      exp = model_read(0);
      bus_read(0, d, lat);
      checks++; if (d !== exp || lat != 1) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, d, exp); end
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] d, exp;
    int lat;
    for (int i = 0; i < D; i++) push1(3, 16'($urandom()));
    read = 1'b1; address = SA'(3);
    port_write = 4'b1000; port_in = '0; port_in[3*W +: W] = 16'h0077;
    tick();
    read = 1'b0; port_write = '0;
    exp = model_read(3);
    model_push(3, 16'h0077);
    checks++; if (ready_r !== 1'b1 || data_out !== exp) begin errors++; $display("FAIL pp_read: got %b %h expected 1 %h", ready_r, data_out, exp); end
    checks++; if (port_full[3] !== 1'b1) begin errors++; $display("FAIL pp_full: got %b expected 1", port_full[3]); end
    tick();
    exp = model_read(SZ);
    bus_read(SZ, d, lat);
    checks++; if (d !== exp || d[11] !== 1'b0) begin errors++; $display("FAIL pp_status: got %h expected %h", d, exp); end
    for (int i = 0; i < 4; i++) begin
      exp = model_read(3);
      bus_read(3, d, lat);
      checks++; if (d !== exp) begin errors++; $display("FAIL pp_drain%0d: got %h expected %h", i, d, exp); end
    end
    checks++; if (d !== 16'h0077) begin errors++; $display("FAIL pp_last: got %h expected 0077", d); end
  endtask

  task automatic test_flush_wrap();
    logic [15:0] d, exp;
    logic ack;
    int lat, early;
    for (int k = 0; k < 6; k++) begin
      push1(0, 16'($urandom()));
      if (k % 2 == 1) begin
        exp = model_read(0);
        bus_read(0, d, lat);
        checks++; if (d !== exp) begin errors++; $display("FAIL wrap_read%0d: got %h expected %h", k, d, exp); end
      end
    end
    for (int k = 0; k < 2; k++) push1(0, 16'($urandom()));
    push1(0, 16'hDEAD);
    checks++; if (movf[0] !== 1'b1 || port_full[0] !== 1'b1) begin errors++; $display("FAIL wrap_fill: got full %b expected 1", port_full[0]); end
    checks++; if (ready_w !== 1'b0) begin errors++; $display("FAIL flush_idle_rw: got %b expected 0", ready_w); end
    bus_write(0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL flush_ready_w: got %b expected 1", ack); end
    tick();
    checks++; if (ready_w !== 1'b0 || port_full[0] !== 1'b0) begin errors++; $display("FAIL flush_after: got rw %b full %b expected 0 0", ready_w, port_full[0]); end
    exp = model_read(SZ);
    bus_read(SZ, d, lat);
    checks++; if (d !== exp) begin errors++; $display("FAIL flush_status: got %h expected %h", d, exp); end
    read = 1'b1; write = 1'b1; address = SA'(2);
    tick();
    read = 1'b0; write = 1'b0;
    mq[2].delete(); movf[2] = 1'b0;
    checks++; if (ready_w !== 1'b1 || ready_r !== 1'b0) begin errors++; $display("FAIL rw_same: got rw %b rr %b expected 1 0", ready_w, ready_r); end
    tick();
    checks++; if (ready_r !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %b expected 0", ready_r); end
    read = 1'b1; address = SA'(0);
    tick();
    read  = 1'b0;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready_r === 1'b1) early++;
      tick();
    end
    checks++; if (early != 0) begin errors++; $display("FAIL flush_wait: got %0d early acks expected 0", early); end
    port_write = 4'b0001; port_in = '0; port_in[0 +: W] = 16'h5A5A;
    tick();
    port_write = '0;
    checks++; if (ready_r !== 1'b1 || data_out !== 16'h5A5A) begin errors++; $display("FAIL flush_wait_data: got %b %h expected 1 5a5a", ready_r, data_out); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] d, exp;
    logic ack;
    int lat, op, a;
    logic [SZ-1:0] m;
    logic [SZ*W-1:0] v;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        m = SZ'($urandom());
        v = {$urandom(), $urandom()};
        port_write = m; port_in = v;
        tick();
        port_write = '0;
        for (int c = 0; c < SZ; c++) if (m[c]) model_push(c, v[c*W +: W]);
        checks++; if (port_full !== model_full()) begin errors++; $display("FAIL rnd_full it%0d: got %b expected %b", it, port_full, model_full()); end
      end else if (op <= 7) begin
        a = $urandom_range(0, 7);
        if (a < SZ && mq[a].size() == 0) a = SZ;
        exp = model_read(a);
        bus_read(a, d, lat);
        checks++; if (d !== exp || lat != 1) begin errors++; $display("FAIL rnd_read it%0d a%0d: got %h lat %0d expected %h lat 1", it, a, d, lat, exp); end
      end else if (op == 8) begin
        a = $urandom_range(0, 7);
        bus_write(a, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rnd_write it%0d: got %b expected 1", it, ack); end
        tick();
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset_wait();
    logic [15:0] d, exp;
    logic ack;
    int lat;
    push1(0, 16'hBEEF);
    exp = model_read(0);
    bus_read(0, d, lat);
    bus_write(1, ack);
    tick();
    read = 1'b1; address = SA'(1);
    tick();
    read = 1'b0;
    tick(); tick();
    checks++; if (ready_r !== 1'b0 || data_out !== exp) begin errors++; $display("FAIL rw_pending: got %b %h expected 0 %h", ready_r, data_out, exp); end
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++; if (ready_r !== 1'b0 || data_out !== 16'h0 || port_full !== '0) begin errors++; $display("FAIL rst_wait: got %b %h %b expected 0 0000 0", ready_r, data_out, port_full); end
    tick();
    reset = 1'b1;
    tick();
    push1(1, 16'h1111);
    checks++; if (ready_r !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got %b expected 0", ready_r); end
    tick();
    checks++; if (ready_r !== 1'b0) begin errors++; $display("FAIL rst_no_ack2: got %b expected 0", ready_r); end
    exp = model_read(SZ);
    bus_read(SZ, d, lat);
    checks++; if (d !== exp) begin errors++; $display("FAIL rst_status: got %h expected %h", d, exp); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_blocking_read();
    test_overflow();
    test_full_push_pop();
    test_flush_wrap();
    test_random();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_fifo.md
# gpio_in_fifo

Buffered, multi-channel general-purpose input peripheral on the CPU memory bus. Each channel owns a FIFO that external logic fills through a per-channel write strobe; the CPU drains it with blocking reads that stall until data arrives. A status register reports non-empty and sticky overflow flags. This block is the FIFO-buffered, width- and depth-parametrised successor to the single-register input port.

## Interface
- `size_addr`, default 3: bus address bits; must satisfy `2**size_addr > size`.
- `size`, default 4: channel count, 1..8.
- `width`, default 16: port data width, 1..16; zero-extended onto the bus.
- `depth`, default 4: FIFO entries per channel, power of two, at least 2.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `read` input, 1 bit: one-cycle bus read request.
- `write` input, 1 bit: one-cycle bus write request.
- `address` input, `size_addr` bits: register select.
- `data_in` input, 16 bits: bus write data, ignored.
- `data_out` output, 16 bits: registered read data, valid while `ready_r` is 1.
- `ready_r` output, 1 bit: one-cycle read-completion pulse.
- `ready_w` output, 1 bit: one-cycle write-completion pulse.
- `port_write` input, `size` bits: per-channel push strobe.
- `port_in` input, `size*width` bits: channel i data is `[i*width +: width]`.
- `port_full` output, `size` bits: per-channel FIFO-full flag, combinational from occupancy.

## Operation
- **Address map**
  - Address 0..size-1 selects a channel data register.
  - Address `size` selects the status register.
  - Higher addresses are unmapped.
- **Push**
  - Pushing when not full stores the data and increments the count.
  - Pushing when full with no same-cycle pop of that channel drops the data and sets `ovf[i]`.
  - Pushing when full with a same-cycle pop is accepted; the count is unchanged.
- **Read FSM**, states IDLE, WAIT, ACK. The address is latched on acceptance.
  - IDLE + `read` on a non-empty channel goes to ACK. The head entry is loaded into `data_out` and popped.
  - IDLE + `read` on an empty channel goes to WAIT.
  - WAIT goes to ACK on the first cycle the latched channel is non-empty, including a push that arrives the same cycle the read is accepted. It pops that entry.
  - WAIT has no timeout.
  - ACK drives `ready_r`=1 for one cycle, then returns to IDLE.
  - `read` in WAIT or ACK is ignored. Masters must not issue one.
  - A status read (address `size`) goes to ACK. `data_out` = {`ovf`[7:0], `nonempty`[7:0]}, with unused bits 0. All `ovf` bits clear on the same edge.
  - An unmapped read goes to ACK with `data_out` = 0.
- **Write**
  - `write` to a channel address flushes that FIFO: count and pointers go to 0 and `ovf[i]` clears.
  - `write` to the status address or an unmapped address has no effect.
  - `ready_w` is `write` delayed one cycle, in every state.
  - If a flush coincides with a push to the same channel, the flush wins and the push is discarded.
  - A flush of a channel with a pending WAIT leaves the read pending.
  - If `read` and `write` are asserted in the same cycle, the write is performed and the read is dropped.
- **Pointers and count**
  - Pointers are `log2(depth)` bits and wrap modulo `depth`.
  - Count is `log2(depth)+1` bits.
  - `port_full[i]` = (count == depth).
- **Reset** (asynchronous, at any point, including mid-WAIT)
  - All FIFOs empty and `ovf` clear.
  - FSM to IDLE.
  - `data_out` = 0, `ready_r` = 0, `ready_w` = 0, `port_full` = 0.

## Timing
- **Read of a non-empty channel**: `read` at cycle t gives `ready_r` and valid `data_out` at t+1. `data_out` holds until the next ACK.
- **Read of an empty channel**: a push at cycle p (p ≥ t) gives `ready_r` at p+1, carrying that pushed value.
- **Write**: `write` at t gives `ready_w` at t+1. The flush takes effect at the t edge.
- **Push**: a push at t is visible in `port_full` and status from t+1.
- **Throughput**: back-to-back reads are accepted every 2 cycles (IDLE, ACK).

## Structure
- A shared include holds:
  - state encodings IDLE=2'd0, WAIT=2'd1, ACK=2'd2;
  - the status-field layout constants.
- Sub-module `gpio_in_fifo_chan` (params `width`, `depth`):
  - one channel's storage, read/write pointers and count;
  - inputs push, pop, flush;
  - outputs head, empty, full, and an overflow pulse.
  - It is instantiated `size` times in a generate loop.
- The top level holds the FSM, the address decode, the `ovf` register, and the output registers.

## Test plan
- **Basic read**: push 0x1234 on ch2, then read address 2 → `ready_r` one cycle later, `data_out`=0x1234; status low byte bit2 = 0 afterwards.
- **Blocking read**: read address 1 while ch1 is empty, wait 10 cycles, push 0x00AB → `ready_r` exactly 1 cycle after the push, with `data_out`=0x00AB.
- **Overflow**: depth=4; push 0x11, 0x22, 0x33, 0x44, 0x55 on ch0.
  - `port_full[0]`=1 after the 4th push.
  - Status reads 0x0101, then 0x0001 on the next status read.
  - Four reads return 0x11, 0x22, 0x33, 0x44.
- **Full with simultaneous push/pop**: ch3 full; push 0x77 in the same cycle a read of ch3 is accepted → pop and push both succeed, `ovf[3]` stays 0, and the 4th subsequent read returns 0x77.
- **Flush and wrap**: push 6 items with interleaved reads so the pointers wrap; then write address 0 → `ready_w` at t+1, ch0 empty, next read enters WAIT.
- **Reset during WAIT**: pull `reset` low → `ready_r`=0, `data_out`=0, and after reset release a push does not produce `ready_r`.
